rtc_port_source: RTL

- Calendar/time-of-day source answering CPU port-input (op 0010) and port-output (op 0011) accesses on the misc I/O bus.
- Keeps seconds/minutes/hours/days/months/years counters advanced by a clock prescaler, so programs read the time instead of computing it.
- Sits beside the misc manager on the same cs/op/port/data/result bus and shares its port numbering (0 = seconds … 5 = years).

---
 rtl/rtc_port_source.sv | 81 ++++++++
 1 files changed

// File: rtl/rtc_port_source.sv
// rtc_port_source: calendar/time-of-day counters served as read/write ports on the misc I/O bus
module rtc_port_source #(
    parameter int data_size     = 16,
    parameter int TICKS_PER_SEC = 100000,
    parameter int RESET_YEAR    = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic [3:0]           op,
    input  logic [data_size-1:0] port,
    input  logic [data_size-1:0] data,
    output logic [data_size-1:0] result
);
    typedef logic [data_size-1:0] word_t;
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam word_t RST_F [6] = '{'0, '0, '0, word_t'(1), word_t'(1), word_t'(RESET_YEAR)};

    // days in month m of year y; out-of-range months behave as 31-day months
    function automatic word_t dim(word_t m, word_t y);
        logic leap;
        leap = (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
        return m == 2 ? (leap ? word_t'(29) : word_t'(28)) :
               (m == 4 || m == 6 || m == 9 || m == 11) ? word_t'(30) : word_t'(31);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    word_t         f_q [6];
    word_t         f_d [6];
    word_t         sh_q [6];
    word_t         rd_val;
    logic          tick_flag_q;
    logic          rd, wr, wr_live, at_term, tick, c;
    logic [5:0]    wrap;
    logic [2:0]    idx;

    assign rd      = cs && op == 4'b0010;
    assign wr      = cs && op == 4'b0011;
    assign wr_live = wr && port < 6;
    assign idx     = port[2:0];
    assign at_term = presc_q == PW'(TICKS_PER_SEC - 1);
    // a write to a live field suppresses the tick: port 0 discards it, ports 1-5 defer it by holding the prescaler
    assign tick    = at_term && !wr_live;

    // prescaler, field roll-over chain with write override, and read mux
    always_comb begin
        presc_d = (wr && port == 0) ? '0 : (at_term && wr_live) ? presc_q : at_term ? '0 : presc_q + 1'b1;
        wrap[0] = f_q[0] >= word_t'(59);
        wrap[1] = f_q[1] >= word_t'(59);
        wrap[2] = f_q[2] >= word_t'(23);
        wrap[3] = f_q[3] >= dim(f_q[4], f_q[5]);
        wrap[4] = f_q[4] >= word_t'(12);
        wrap[5] = 1'b0;
        c = tick;
        for (int i = 0; i < 6; i++) begin
            f_d[i] = !c ? f_q[i] : wrap[i] ? (i >= 3 ? word_t'(1) : '0) : f_q[i] + 1'b1;
            if (wr_live && idx == 3'(i)) f_d[i] = data;
            c = c && wrap[i];
        end
        rd_val = port == 0 ? f_q[0] :
                 (port >= 1 && port <= 5) ? sh_q[idx] :
                 port == 6 ? word_t'(tick_flag_q) : '0;
    end

    // state registers; a port-0 read snapshots minutes..years for coherent follow-up reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            f_q         <= RST_F;
            sh_q        <= RST_F;
            tick_flag_q <= 1'b0;
            result      <= '0;
        end else begin
            presc_q     <= presc_d;
            f_q         <= f_d;
            if (rd && port == 0) sh_q <= f_q;
            tick_flag_q <= tick ? 1'b1 : (rd && port == 6) ? 1'b0 : tick_flag_q;
            result      <= rd ? rd_val : '0;
        end
    end
endmodule
